// File: rtl/i2c_register_bank.sv
// Byte-wide register bank behind an I2C peripheral: owns the register pointer,
// serves read/write handshakes with auto-increment, RW control and RO status registers.
module i2c_register_bank #(
   parameter int          NUM_RW_REGS    = 8,
   parameter int          NUM_RO_REGS    = 4,
   parameter logic [7:0]  RW_RESET_VALUE = 8'h00
) (
   input  logic                        i_sys_clk,
   input  logic                        i_rst,
   input  logic                        i_address_load,
   input  logic [7:0]                  i_register_address,
   input  logic                        i_read_enable,
   output logic [7:0]                  o_register_data,
   output logic                        o_read_valid,
   input  logic                        i_read_ack,
   input  logic [7:0]                  i_register_data,
   input  logic                        i_write_valid,
   output logic                        o_write_ack,
   output logic [8*NUM_RW_REGS-1:0]    o_rw_regs,
   output logic [NUM_RW_REGS-1:0]      o_rw_write_strobe,
   input  logic [8*NUM_RO_REGS-1:0]    i_ro_regs,
   output logic [NUM_RO_REGS-1:0]      o_ro_read_strobe,
   output logic                        o_access_error,
   input  logic                        i_error_clear,
   output logic [1:0]                  debug_state,
   output logic [7:0]                  debug_pointer
);

   localparam int TOTAL = NUM_RW_REGS + NUM_RO_REGS;

   // Handshakes: a request (i_write_valid / i_read_enable) is taken only in IDLE.
   // A write is answered by a one-cycle o_write_ack on the next cycle; a read raises
   // o_read_valid on the next cycle and holds it with frozen data until the cycle
   // in which i_read_ack is high (or an address load aborts the read).
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_WAIT  = 2'd1,
      WRITE_DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [7:0]  pointer;
   logic [7:0]  ea;
   logic [7:0]  rd_mux;
   logic        do_write;
   logic        do_read;
   logic        do_ack;
   logic        do_abort;
   logic        error_set;

   function automatic logic [7:0] incr(input logic [7:0] a);
      if ({1'b0, a} >= 9'(TOTAL - 1)) return 8'h00;
      return a + 8'd1;
   endfunction

   assign ea            = i_address_load ? i_register_address : pointer;
   assign debug_state   = state;
   assign debug_pointer = pointer;

   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      do_write   = 1'b0;
      do_read    = 1'b0;
      do_ack     = 1'b0;
      do_abort   = 1'b0;
      case (state)
         IDLE: begin
            if (i_write_valid) begin
               do_write   = 1'b1;
               next_state = WRITE_DONE;
            end else if (i_read_enable) begin
               do_read    = 1'b1;
               next_state = READ_WAIT;
            end
         end
         READ_WAIT: begin
            // An address load abandons the pending read, even if acked this cycle.
            if (i_address_load) begin
               do_abort   = 1'b1;
               next_state = IDLE;
            end else if (i_read_ack) begin
               do_ack     = 1'b1;
               next_state = IDLE;
            end
         end
         WRITE_DONE: next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = 8'h00;
      for (int i = 0; i < NUM_RW_REGS; i++)
         if (ea == 8'(i)) rd_mux = o_rw_regs[8*i +: 8];
      for (int j = 0; j < NUM_RO_REGS; j++)
         if (ea == 8'(NUM_RW_REGS + j)) rd_mux = i_ro_regs[8*j +: 8];
   end

   assign error_set = (do_write && ({1'b0, ea} >= 9'(NUM_RW_REGS))) ||
                      (do_read  && ({1'b0, ea} >= 9'(TOTAL)));

   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         pointer           <= 8'h00;
         o_rw_regs         <= {NUM_RW_REGS{RW_RESET_VALUE}};
         o_register_data   <= 8'h00;
         o_read_valid      <= 1'b0;
         o_write_ack       <= 1'b0;
         o_rw_write_strobe <= '0;
         o_ro_read_strobe  <= '0;
         o_access_error    <= 1'b0;
      end else begin
         o_write_ack       <= do_write;
         o_rw_write_strobe <= '0;
         o_ro_read_strobe  <= '0;

         if (do_write)                    pointer <= incr(ea);
         else if (do_read)                pointer <= ea;
         else if (do_ack)                 pointer <= incr(pointer);
         else if (i_address_load)         pointer <= i_register_address;

         for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (do_write && ea == 8'(i)) begin
               o_rw_regs[8*i +: 8]  <= i_register_data;
               o_rw_write_strobe[i] <= 1'b1;
            end
         end

         if (do_read) begin
            o_register_data <= rd_mux;
            o_read_valid    <= 1'b1;
         end else if (do_ack || do_abort) begin
            o_read_valid    <= 1'b0;
         end

         for (int j = 0; j < NUM_RO_REGS; j++)
            if (do_ack && pointer == 8'(NUM_RW_REGS + j)) o_ro_read_strobe[j] <= 1'b1;

         if (error_set)          o_access_error <= 1'b1;
         else if (i_error_clear) o_access_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2c_register_bank.sv
// Directed bench for i2c_register_bank: writes, RO read with wrap, access errors,
// read abort, back-to-back reads, write/read collision and reset during a read.
module tb_i2c_register_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        address_load;
   logic [7:0]  register_address;
   logic        read_enable;
   logic [7:0]  rdata;
   logic        read_valid;
   logic        read_ack;
   logic [7:0]  wdata;
   logic        write_valid;
   logic        write_ack;
   logic [63:0] rw_regs;
   logic [7:0]  rw_write_strobe;
   logic [31:0] ro_regs;
   logic [3:0]  ro_read_strobe;
   logic        access_error;
   logic        error_clear;
   logic [1:0]  dbg_state;
   logic [7:0]  dbg_pointer;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   i2c_register_bank dut (
      .i_sys_clk          (clk),
      .i_rst              (rst),
      .i_address_load     (address_load),
      .i_register_address (register_address),
      .i_read_enable      (read_enable),
      .o_register_data    (rdata),
      .o_read_valid       (read_valid),
      .i_read_ack         (read_ack),
      .i_register_data    (wdata),
      .i_write_valid      (write_valid),
      .o_write_ack        (write_ack),
      .o_rw_regs          (rw_regs),
      .o_rw_write_strobe  (rw_write_strobe),
      .i_ro_regs          (ro_regs),
      .o_ro_read_strobe   (ro_read_strobe),
      .o_access_error     (access_error),
      .i_error_clear      (error_clear),
      .debug_state        (dbg_state),
      .debug_pointer      (dbg_pointer)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      address_load = 1'b0; register_address = 8'h00; read_enable = 1'b0;
      read_ack = 1'b0; wdata = 8'h00; write_valid = 1'b0; error_clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear_inputs(); ro_regs = 32'h3C33_2211;
      step(); step();
      tests_run++; if (rw_regs !== 64'h0) begin tests_failed++; $display("FAIL reset_rw: got %h expected 0", rw_regs); end
      tests_run++; if ({read_valid, write_ack, access_error} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {read_valid, write_ack, access_error}); end
      tests_run++; if ({rdata, dbg_pointer, dbg_state} !== 18'h0) begin tests_failed++; $display("FAIL reset_data_ptr_state: got %h expected 0", {rdata, dbg_pointer, dbg_state}); end
      tests_run++; if ({rw_write_strobe, ro_read_strobe} !== 12'h0) begin tests_failed++; $display("FAIL reset_strobes: got %h expected 0", {rw_write_strobe, ro_read_strobe}); end
      rst = 1'b0; step();
   endtask

   task automatic test_write();
      address_load = 1'b1; register_address = 8'h02; step(); clear_inputs();
      tests_run++; if (dbg_pointer !== 8'h02) begin tests_failed++; $display("FAIL load_ptr: got %h expected 02", dbg_pointer); end
      write_valid = 1'b1; wdata = 8'hA5; step(); clear_inputs();
      tests_run++; if (write_ack !== 1'b1) begin tests_failed++; $display("FAIL wr1_ack: got %b expected 1", write_ack); end
      tests_run++; if (rw_regs !== 64'h0000_0000_00A5_0000) begin tests_failed++; $display("FAIL wr1_regs: got %h expected 0000000000a50000", rw_regs); end
      tests_run++; if (rw_write_strobe !== 8'b0000_0100) begin tests_failed++; $display("FAIL wr1_strobe: got %b expected 00000100", rw_write_strobe); end
      tests_run++; if (dbg_state !== 2'd2) begin tests_failed++; $display("FAIL wr1_state: got %0d expected 2", dbg_state); end
      // Request during WRITE_DONE must be ignored.
      write_valid = 1'b1; wdata = 8'hEE; step(); clear_inputs();
      tests_run++; if ({write_ack, rw_write_strobe, dbg_state} !== 11'h0) begin tests_failed++; $display("FAIL wr_done_ignore: got %h expected 0", {write_ack, rw_write_strobe, dbg_state}); end
      write_valid = 1'b1; wdata = 8'h5A; step(); clear_inputs();
      tests_run++; if (write_ack !== 1'b1) begin tests_failed++; $display("FAIL wr2_ack: got %b expected 1", write_ack); end
      tests_run++; if (rw_regs !== 64'h0000_0000_5AA5_0000) begin tests_failed++; $display("FAIL wr2_regs: got %h expected 000000005aa50000", rw_regs); end
      tests_run++; if (rw_write_strobe !== 8'b0000_1000) begin tests_failed++; $display("FAIL wr2_strobe: got %b expected 00001000", rw_write_strobe); end
      tests_run++; if (dbg_pointer !== 8'h04) begin tests_failed++; $display("FAIL wr2_ptr: got %h expected 04", dbg_pointer); end
      step();
      tests_run++; if ({write_ack, rw_write_strobe} !== 9'h0) begin tests_failed++; $display("FAIL wr2_pulse_end: got %h expected 0", {write_ack, rw_write_strobe}); end
   endtask

   task automatic test_ro_read_wrap();
      address_load = 1'b1; register_address = 8'h0B; step(); clear_inputs();
      read_enable = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, rdata} !== 9'h13C) begin tests_failed++; $display("FAIL ro_rd_first: got %h expected 13c", {read_valid, rdata}); end
      ro_regs = 32'hC333_2211;
      for (int k = 0; k < 4; k++) begin
         step();
         tests_run++; if ({read_valid, rdata, dbg_state} !== 11'h4F1) begin tests_failed++; $display("FAIL ro_rd_hold%0d: got %h expected 4f1", k, {read_valid, rdata, dbg_state}); end
      end
      read_ack = 1'b1; step(); clear_inputs();
      tests_run++; if (read_valid !== 1'b0) begin tests_failed++; $display("FAIL ro_rd_drop: got %b expected 0", read_valid); end
      tests_run++; if (ro_read_strobe !== 4'b1000) begin tests_failed++; $display("FAIL ro_rd_strobe: got %b expected 1000", ro_read_strobe); end
      tests_run++; if (dbg_pointer !== 8'h00) begin tests_failed++; $display("FAIL ro_rd_wrap: got %h expected 00", dbg_pointer); end
      step();
      tests_run++; if (ro_read_strobe !== 4'b0000) begin tests_failed++; $display("FAIL ro_rd_strobe_end: got %b expected 0000", ro_read_strobe); end
      ro_regs = 32'h3C33_2211;
   endtask

   task automatic test_ro_write_error();
      address_load = 1'b1; register_address = 8'h09; write_valid = 1'b1; wdata = 8'hFF; step(); clear_inputs();
      tests_run++; if (write_ack !== 1'b1) begin tests_failed++; $display("FAIL ro_wr_ack: got %b expected 1", write_ack); end
      tests_run++; if ({rw_regs, rw_write_strobe} !== {64'h0000_0000_5AA5_0000, 8'h00}) begin tests_failed++; $display("FAIL ro_wr_nochange: got %h expected 000000005aa5000000", {rw_regs, rw_write_strobe}); end
      tests_run++; if (access_error !== 1'b1) begin tests_failed++; $display("FAIL ro_wr_err: got %b expected 1", access_error); end
      tests_run++; if (dbg_pointer !== 8'h0A) begin tests_failed++; $display("FAIL ro_wr_ptr: got %h expected 0a", dbg_pointer); end
      step(); error_clear = 1'b1; step(); clear_inputs();
      tests_run++; if (access_error !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", access_error); end
   endtask

   task automatic test_unmapped_read();
      // Clear in the same cycle as a new error: the set must win.
      address_load = 1'b1; register_address = 8'h40; read_enable = 1'b1; error_clear = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, rdata} !== 9'h100) begin tests_failed++; $display("FAIL unm_rd_data: got %h expected 100", {read_valid, rdata}); end
      tests_run++; if (access_error !== 1'b1) begin tests_failed++; $display("FAIL unm_rd_err_set_wins: got %b expected 1", access_error); end
      read_ack = 1'b1; step(); clear_inputs();
      tests_run++; if ({dbg_pointer, ro_read_strobe, read_valid} !== 13'h0) begin tests_failed++; $display("FAIL unm_rd_after_ack: got %h expected 0", {dbg_pointer, ro_read_strobe, read_valid}); end
      error_clear = 1'b1; step(); clear_inputs();
   endtask

   task automatic test_read_abort();
      address_load = 1'b1; register_address = 8'h08; read_enable = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, rdata} !== 9'h111) begin tests_failed++; $display("FAIL abort_rd_data: got %h expected 111", {read_valid, rdata}); end
      address_load = 1'b1; register_address = 8'h01; read_ack = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, ro_read_strobe, dbg_state} !== 7'h0) begin tests_failed++; $display("FAIL abort_drop: got %h expected 0", {read_valid, ro_read_strobe, dbg_state}); end
      tests_run++; if (dbg_pointer !== 8'h01) begin tests_failed++; $display("FAIL abort_ptr: got %h expected 01", dbg_pointer); end
   endtask

   task automatic test_back_to_back();
      address_load = 1'b1; register_address = 8'h02; read_enable = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, rdata} !== 9'h1A5) begin tests_failed++; $display("FAIL b2b_rd1: got %h expected 1a5", {read_valid, rdata}); end
      write_valid = 1'b1; wdata = 8'hEE; step(); clear_inputs();
      tests_run++; if ({write_ack, rw_regs} !== {1'b0, 64'h0000_0000_5AA5_0000}) begin tests_failed++; $display("FAIL b2b_wr_ignored: got %h expected 0000000005aa50000", {write_ack, rw_regs}); end
      read_ack = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, dbg_pointer} !== 9'h003) begin tests_failed++; $display("FAIL b2b_ack1: got %h expected 003", {read_valid, dbg_pointer}); end
      read_enable = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, rdata} !== 9'h15A) begin tests_failed++; $display("FAIL b2b_rd2: got %h expected 15a", {read_valid, rdata}); end
      read_ack = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, dbg_pointer} !== 9'h004) begin tests_failed++; $display("FAIL b2b_ack2: got %h expected 004", {read_valid, dbg_pointer}); end
   endtask

   task automatic test_collision_and_reset();
      address_load = 1'b1; register_address = 8'h00; step(); clear_inputs();
      write_valid = 1'b1; read_enable = 1'b1; wdata = 8'h77; step(); clear_inputs();
      tests_run++; if (rw_regs !== 64'h0000_0000_5AA5_0077) begin tests_failed++; $display("FAIL coll_regs: got %h expected 000000005aa50077", rw_regs); end
      tests_run++; if ({write_ack, read_valid, rw_write_strobe} !== 10'b10_0000_0001) begin tests_failed++; $display("FAIL coll_flags: got %b expected 1000000001", {write_ack, read_valid, rw_write_strobe}); end
      tests_run++; if (dbg_pointer !== 8'h01) begin tests_failed++; $display("FAIL coll_ptr: got %h expected 01", dbg_pointer); end
      step();
      address_load = 1'b1; register_address = 8'h09; read_enable = 1'b1; step(); clear_inputs();
      tests_run++; if ({read_valid, rdata} !== 9'h122) begin tests_failed++; $display("FAIL rst_pre_rd: got %h expected 122", {read_valid, rdata}); end
      #1 rst = 1'b1; #1;
      tests_run++; if ({read_valid, rdata, dbg_pointer, dbg_state} !== 19'h0) begin tests_failed++; $display("FAIL rst_mid_read: got %h expected 0", {read_valid, rdata, dbg_pointer, dbg_state}); end
      tests_run++; if (rw_regs !== 64'h0) begin tests_failed++; $display("FAIL rst_mid_rw: got %h expected 0", rw_regs); end
      step(); rst = 1'b0; step();
      tests_run++; if ({read_valid, write_ack, access_error} !== 3'b000) begin tests_failed++; $display("FAIL rst_release: got %b expected 000", {read_valid, write_ack, access_error}); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_ro_read_wrap();
      test_ro_write_error();
      test_unmapped_read();
      test_read_abort();
      test_back_to_back();
      test_collision_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
